// File: rtl/tdc_capture_if.sv
// Readout port of tdc_capture: show-ahead FIFO head record, valid flag and pop request.
// master = FIFO side (drives data/valid), slave = readout logic (drives rd_en).
interface tdc_capture_if #(
    parameter int unsigned RW = 25
);
    logic          rd_en;
    logic [RW-1:0] rd_data;
    logic          rd_valid;

    modport master (input rd_en, output rd_data, output rd_valid);
    modport slave  (output rd_en, input rd_data, input rd_valid);
endinterface

// File: rtl/tdc_capture.sv
// TDC capture: synchronised start/stop strobes, coarse period counter, thermometer fine codes,
// show-ahead record FIFO. Define TDC_BUBBLE_FILTER_EN for popcount fine codes.
module tdc_capture #(
    parameter int unsigned TAPS  = 128,
    parameter int unsigned CW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK12MHZ,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [TAPS-1:0] taps,
    tdc_capture_if.master   rd,
    output logic            busy,
    output logic [7:0]      dropped
);

    localparam int unsigned FW = $clog2(TAPS + 1);
    localparam int unsigned RW = 1 + CW + 2 * FW;
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
    localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [CW-1:0] CrsOne  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Synchronisers
    logic            start_s1_q, start_s2_q, start_s3_q;
    logic            stop_s1_q, stop_s2_q, stop_s3_q;
    logic [TAPS-1:0] taps_s1_q, taps_s2_q;

    always_ff @(posedge CLK12MHZ) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            stop_s1_q  <= 1'b0;
            stop_s2_q  <= 1'b0;
            stop_s3_q  <= 1'b0;
            taps_s1_q  <= '0;
            taps_s2_q  <= '0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            stop_s1_q  <= stop;
            stop_s2_q  <= stop_s1_q;
            stop_s3_q  <= stop_s2_q;
            taps_s1_q  <= taps;
            taps_s2_q  <= taps_s1_q;
        end
    end

    logic start_edge, stop_edge;
    assign start_edge = start_s2_q & ~start_s3_q;
    assign stop_edge  = stop_s2_q & ~stop_s3_q;

    // Fine code from the synchronised tap vector
    logic [FW-1:0] fine_code;
    always_comb begin
        fine_code = '0;
        for (int i = 0; i < TAPS; i++) begin
`ifdef TDC_BUBBLE_FILTER_EN
            fine_code = fine_code + FW'(taps_s2_q[i]);
`else
            if (taps_s2_q[i]) fine_code = FW'(i + 1);
`endif
        end
    end

    // Measurement FSM
    state_e        state_q;
    logic [CW-1:0] coarse_q;
    logic [FW-1:0] fine_start_q, fine_stop_q;
    logic          ovf_q;
    logic          busy_q;

    always_ff @(posedge CLK12MHZ) begin
        if (rst) begin
            state_q      <= StIdle;
            coarse_q     <= '0;
            fine_start_q <= '0;
            fine_stop_q  <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        fine_start_q <= fine_code;
                        fine_stop_q  <= stop_edge ? fine_code : '0;
                        coarse_q     <= '0;
                        ovf_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= stop_edge ? StDone : StRun;
                    end
                end
                StRun: begin
                    // The stop edge still counts its own period, so coarse equals the
                    // synchronised start-to-stop distance; all-ones with no stop is overflow.
                    if (coarse_q == '1) begin
                        ovf_q       <= 1'b1;
                        fine_stop_q <= '0;
                        state_q     <= StDone;
                    end else begin
                        coarse_q <= coarse_q + CrsOne;
                        if (stop_edge) begin
                            fine_stop_q <= fine_code;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // Record FIFO
    logic [RW-1:0] record;
    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    dropped_q;
    logic          full, empty, wr_en, pop, drop;

    assign record = {ovf_q, coarse_q, fine_start_q, fine_stop_q};
    assign full   = (count_q == CntFull);
    assign empty  = (count_q == '0);
    assign wr_en  = (state_q == StDone) & ~full;
    assign drop   = (state_q == StDone) & full;
    assign pop    = rd.rd_en & ~empty;

    always_ff @(posedge CLK12MHZ) begin
        if (wr_en) mem_q[wr_ptr_q] <= record;
    end

    always_ff @(posedge CLK12MHZ) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
            if (drop && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
        end
    end

    // Head is masked while empty so reset shows an all-zero record
    assign rd.rd_valid = ~empty;
    assign rd.rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_tdc_capture.sv
// Self-checking bench for tdc_capture: event-level reference model plus directed literal checks.
module tb_tdc_capture;

    localparam int unsigned TAPS  = 128;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = 25;

    logic            clk, rst, start, stop, busy;
    logic [TAPS-1:0] taps;
    logic [7:0]      dropped;

    tdc_capture_if #(.RW(RW)) rd_if ();

    tdc_capture #(.TAPS(TAPS), .CW(CW), .DEPTH(DEPTH)) dut (
        .CLK12MHZ(clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .taps    (taps),
        .rd      (rd_if),
        .busy    (busy),
        .dropped (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   edge_n = 0;
    logic rst_s  = 1'b0;
    logic en_s   = 1'b0;
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_s  <= rst;
        en_s   <= rd_if.rd_en;
    end

    // Model: each measurement is its start-edge cycle, DONE cycle and record
    int            m_e[64];
    int            m_dn[64];
    logic [RW-1:0] m_rec[64];
    int            nm       = 0;
    logic [RW-1:0] mq[$];
    int            m_drop   = 0;
    int            last_rst = 0;
    int            busy_cnt = 0;
    int            n_pass   = 0;
    int            n_total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    endtask

    function automatic logic [7:0] fine_of(input logic [TAPS-1:0] t);
`ifdef TDC_BUBBLE_FILTER_EN
        return 8'($countones(t));
`else
        for (int i = TAPS - 1; i >= 0; i--) if (t[i]) return 8'(i + 1);
        return 8'd0;
`endif
    endfunction

    // ks: first edge sampling start; d: stop offset in cycles (negative = never)
    task automatic push_meas(input int ks, input int d, input logic [TAPS-1:0] ts,
                             input logic [TAPS-1:0] tp, output int dn);
        logic [RW-1:0] r;
        if (d >= 0 && d <= 255) begin
            dn = ks + d + 2;
            r  = {1'b0, 8'(d), fine_of(ts), fine_of(tp)};
        end else begin
            dn = ks + 2 + 256;
            r  = {1'b1, 8'hFF, fine_of(ts), 8'h00};
        end
        m_e[nm]   = ks + 2;
        m_dn[nm]  = dn;
        m_rec[nm] = r;
        nm++;
    endtask

    always @(negedge clk) begin
        bit   full;
        logic bx;
        if (edge_n >= 1) begin
            if (rst_s) begin
                mq.delete();
                m_drop   = 0;
                last_rst = edge_n;
            end else begin
                full = (mq.size() == DEPTH);
                if (en_s && mq.size() > 0) void'(mq.pop_front());
                for (int i = 0; i < nm; i++) begin
                    if (m_e[i] > last_rst && m_dn[i] + 1 == edge_n) begin
                        if (full) begin
                            if (m_drop < 255) m_drop++;
                        end else mq.push_back(m_rec[i]);
                    end
                end
            end
            bx = 1'b0;
            for (int i = 0; i < nm; i++)
                if (m_e[i] > last_rst && m_e[i] <= edge_n && edge_n <= m_dn[i]) bx = 1'b1;
            if (busy === 1'b1) busy_cnt++;
            chk("rd_valid", 32'(rd_if.rd_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("rd_data", 32'(rd_if.rd_data), 32'(mq[0]));
            chk("busy", 32'(busy), 32'(bx));
            chk("dropped", 32'(dropped), 32'(m_drop));
        end
    end

    task automatic meas(input int d, input logic [TAPS-1:0] ts, input logic [TAPS-1:0] tp,
                        output int kp, output int dn);
        int ks;
        @(negedge clk);
        ks = edge_n + 1;
        kp = ks + d;
        push_meas(ks, d, ts, (d == 0) ? ts : tp, dn);
        start = 1'b1;
        taps  = ts;
        if (d == 0) stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (d == 0) stop = 1'b0;
        else if (d > 0) begin
            repeat (d - 1) @(negedge clk);
            stop = 1'b1;
            taps = tp;
            @(negedge clk);
            stop = 1'b0;
        end
    endtask

    task automatic wait_idle(input int dn);
        while (edge_n < dn + 2) @(negedge clk);
    endtask

    task automatic pop(input string name, input logic [RW-1:0] exp);
        chk({name, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        chk(name, 32'(rd_if.rd_data), 32'(exp));
        rd_if.rd_en = 1'b1;
        @(negedge clk);
        rd_if.rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            kp, dn, b0;
        logic [TAPS-1:0] t;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        taps = '0;
        rd_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("rst_data", 32'(rd_if.rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Same-cycle start/stop
        meas(0, 128'hFFFF_FFFF, '0, kp, dn);
        while (edge_n < kp + 2) @(negedge clk);
        chk("lat_early", 32'(rd_if.rd_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(rd_if.rd_valid), 32'd1);
        pop("same_cycle_rec", 25'h0002020);
        wait_idle(dn);

        // Stop 10 cycles after start
        b0 = busy_cnt;
        meas(10, 128'hF, 128'hFF, kp, dn);
        wait_idle(dn);
        chk("busy_len", 32'(busy_cnt - b0), 32'd11);
        pop("stop10_rec", 25'h00A0408);

        // No stop: overflow
        meas(-1, 128'h1, '0, kp, dn);
        wait_idle(dn);
        chk("ovf_idle", 32'(busy), 32'd0);
        pop("ovf_rec", 25'h1FF0100);

        // Bubble in thermometer code
        meas(0, 128'hB, '0, kp, dn);
        wait_idle(dn);
`ifdef TDC_BUBBLE_FILTER_EN
        pop("bubble_rec", 25'h0000303);
`else
        pop("bubble_rec", 25'h0000404);
`endif

        // Six measurements without reading
        for (int i = 0; i < 6; i++) begin
            t = (128'd1 << (i + 1)) - 128'd1;
            meas(0, t, '0, kp, dn);
            wait_idle(dn);
        end
        chk("dropped_two", 32'(dropped), 32'd2);
        for (int n = 1; n <= 4; n++) pop("fifo_order", {1'b0, 8'd0, 8'(n), 8'(n)});
        chk("drain_valid", 32'(rd_if.rd_valid), 32'd0);

        // Reset during RUN with two records queued
        meas(0, 128'h1F, '0, kp, dn);
        wait_idle(dn);
        meas(0, 128'h3F, '0, kp, dn);
        wait_idle(dn);
        @(negedge clk);
        push_meas(edge_n + 1, -1, 128'h3, '0, dn);
        start = 1'b1;
        taps = 128'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        chk("queued_valid", 32'(rd_if.rd_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("post_rst_dropped", 32'(dropped), 32'd0);
        repeat (3) @(negedge clk);
        meas(0, 128'hFF, '0, kp, dn);
        wait_idle(dn);
        pop("post_rst_rec", 25'h0000808);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
